// File: rtl/image_op_sequencer_pkg.sv
// image_op_sequencer_pkg: shared FSM encoding, command field layout and watchdog limit.
package image_op_sequencer_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN, ST_FINISH} state_t;
    // Offsets are relative to the end of the translateY/translateX fields.
    localparam int OFF_INVX = 0;
    localparam int OFF_INVY = 1;
    localparam int OFF_OPC  = 2;
    localparam int OFF_SRCA = 5;
    localparam int OFF_SRCB = 7;
    localparam int OFF_DST  = 9;
    localparam int OFF_TAG  = 11;
    localparam int OPC_W    = 3;
    localparam int SEL_W    = 2;
    localparam int TAG_W    = 4;
    localparam int WD_LIMIT = 15;
endpackage

// File: rtl/image_op_sequencer_fifo.sv
// cmd_fifo: synchronous command queue with flush; no push/pop bypass.
module cmd_fifo
    import image_op_sequencer_pkg::*;
#(
    parameter int Width     = 8,
    parameter int DepthLog2 = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 push,
    input  logic                 pop,
    input  logic [Width-1:0]     din,
    output logic [Width-1:0]     dout,
    output logic                 full,
    output logic                 empty,
    output logic [DepthLog2:0]   count
);
    logic [Width-1:0]   r_mem [2**DepthLog2];
    logic [DepthLog2:0] r_wp;
    logic [DepthLog2:0] r_rp;
    logic               w_wr;
    logic               w_rd;
    assign count = r_wp - r_rp;
    assign full  = count[DepthLog2];
    assign empty = count == '0;
    assign dout  = r_mem[r_rp[DepthLog2-1:0]];
    assign w_wr  = push && !full && !flush;
    assign w_rd  = pop && !empty && !flush;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            r_wp <= r_wp + (DepthLog2+1)'(w_wr);
            r_rp <= r_rp + (DepthLog2+1)'(w_rd);
        end
    end
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp[DepthLog2-1:0]] <= din;
    end
endmodule

// File: rtl/image_op_sequencer.sv
// image_op_sequencer: queues image-processor commands and steps each one through
// arm/run/finish, driving the processor clock enable and per-command configuration.
module image_op_sequencer
    import image_op_sequencer_pkg::*;
#(
    parameter int WidthAddressSize  = 8,
    parameter int HeightAddressSize = 8,
    parameter int DepthLog2         = 2,
    localparam int CmdWidth         = 15 + WidthAddressSize + HeightAddressSize
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CmdWidth-1:0]          cmd,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         flush,
    input  logic                         pause,
    input  logic                         proc_busy,
    output logic                         proc_ce,
    output logic [2:0]                   proc_opcode,
    output logic                         proc_invertX,
    output logic                         proc_invertY,
    output logic [WidthAddressSize-1:0]  proc_translateX,
    output logic [HeightAddressSize-1:0] proc_translateY,
    output logic [1:0]                   buf_sel_a,
    output logic [1:0]                   buf_sel_b,
    output logic [1:0]                   buf_sel_dst,
    output logic                         done,
    output logic [3:0]                   done_tag,
    output logic                         error,
    output logic [DepthLog2:0]           occupancy,
    output logic                         idle
);
    localparam int Base = WidthAddressSize + HeightAddressSize;
    state_t              r_state;
    state_t              w_next;
    logic [CmdWidth-1:0] r_cmd;
    logic [3:0]          r_wd;
    logic                r_error;
    logic [CmdWidth-1:0] w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_timeout;
    cmd_fifo #(.Width(CmdWidth), .DepthLog2(DepthLog2)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (w_push),
        .pop   (w_pop),
        .din   (cmd),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (occupancy)
    );
    assign cmd_ready = !w_full && !flush;
    assign w_push    = cmd_valid && cmd_ready;
    // A flushed head is discarded rather than started.
    assign w_pop     = r_state == ST_IDLE && !w_empty && !flush;
    assign w_timeout = r_state == ST_ARM && !proc_busy && !pause && r_wd == 4'(WD_LIMIT - 1);
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = w_pop ? ST_ARM : ST_IDLE;
            ST_ARM:  w_next = proc_busy ? ST_RUN : (w_timeout ? ST_IDLE : ST_ARM);
            ST_RUN:  w_next = proc_busy ? ST_RUN : ST_FINISH;
            default: w_next = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_wd    <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_pop) begin
                r_cmd <= w_head;
                r_wd  <= '0;
            end else if (r_state == ST_ARM && !pause) begin
                r_wd  <= r_wd + 4'd1;
            end
            if (w_timeout) r_error <= 1'b1;
        end
    end
    // Gating on proc_busy in RUN keeps the processor from restarting once it drops busy.
    assign proc_ce         = !pause && (r_state == ST_ARM || (r_state == ST_RUN && proc_busy));
    assign done            = r_state == ST_FINISH;
    assign done_tag        = r_cmd[Base+OFF_TAG +: TAG_W];
    assign error           = r_error;
    assign idle            = r_state == ST_IDLE && w_empty;
    assign proc_opcode     = r_cmd[Base+OFF_OPC +: OPC_W];
    assign proc_invertX    = r_cmd[Base+OFF_INVX];
    assign proc_invertY    = r_cmd[Base+OFF_INVY];
    assign proc_translateX = r_cmd[WidthAddressSize-1:0];
    assign proc_translateY = r_cmd[Base-1:WidthAddressSize];
    assign buf_sel_a       = r_cmd[Base+OFF_SRCA +: SEL_W];
    assign buf_sel_b       = r_cmd[Base+OFF_SRCB +: SEL_W];
    assign buf_sel_dst     = r_cmd[Base+OFF_DST +: SEL_W];
endmodule
